// File: rtl/ct_f_spsram_bank.sv
// ct_f_spsram_bank
// One write bank of the banked single-port SRAM: BANK_WIDTH x 2**ADDR_WIDTH
// data storage plus a same-shaped taint shadow array, a write-first read
// register and a zero-fill write port used while the top is initialising.
//
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset (clears the read register and
//              blocks any write in the reset cycle)
//   init_fill  1 = zero-fill mode: write 0 at init_addr, read register held 0
//   init_addr  zero-fill address
//   we         normal-mode write enable for this bank (data and shadow)
//   addr       normal-mode access address
//   d, d_t     write data and write taint for this bank
//   q, q_t     registered read data and read taint (write-first)
module ct_f_spsram_bank #(
  parameter int ADDR_WIDTH = 7,
  parameter int BANK_WIDTH = 26
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  init_fill,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BANK_WIDTH-1:0] d,
  input  logic [BANK_WIDTH-1:0] d_t,
  output logic [BANK_WIDTH-1:0] q,
  output logic [BANK_WIDTH-1:0] q_t
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [BANK_WIDTH-1:0] mem    [DEPTH];
  logic [BANK_WIDTH-1:0] shadow [DEPTH];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BANK_WIDTH-1:0] wr_data;
  logic [BANK_WIDTH-1:0] wr_taint;

  // Zero-fill takes over the single write port while initialising.
  always_comb begin
    wr_en    = we;
    wr_addr  = addr;
    wr_data  = d;
    wr_taint = d_t;
    if (init_fill) begin
      wr_en    = 1'b1;
      wr_addr  = init_addr;
      wr_data  = '0;
      wr_taint = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && wr_en) begin
      mem[wr_addr]    <= wr_data;
      shadow[wr_addr] <= wr_taint;
    end
  end

  // Read register: written banks return the incoming word, others the
  // stored word. Held at zero during reset and zero-fill.
  always_ff @(posedge CLK) begin
    if (RST || init_fill) begin
      q   <= '0;
      q_t <= '0;
    end else if (we) begin
      q   <= d;
      q_t <= d_t;
    end else begin
      q   <= mem[addr];
      q_t <= shadow[addr];
    end
  end

endmodule

// File: rtl/ct_f_spsram_banked_init.sv
// ct_f_spsram_banked_init
// Parametrised single-port SRAM wrapper with per-bank write masking,
// post-reset zero initialisation, optional output register and a taint
// shadow array tracking the taint of stored data.
//
// Ports:
//   CLK   clock            RST  synchronous active-high reset
//   CEN   chip enable (active-low)   GWEN global write enable (active-low)
//   WEN   per-bit write mask (active-low); bank i obeys bit (i+1)*BANK_WIDTH-1
//   A, D  address and write data      Q    read data
//   BUSY  initialisation in progress, all accesses ignored
//   A_t0, CEN_t0, GWEN_t0, WEN_t0, D_t0  input taints;  Q_t0 taint of Q
//
// Handshake: there is none. In RUN every cycle is an access cycle; with CEN
// low the access uses A (and A is remembered), with CEN high the remembered
// address is re-read so Q stays stable. While BUSY is high inputs are ignored.
module ct_f_spsram_banked_init #(
  parameter int ADDR_WIDTH = 7,
  parameter int BANK_WIDTH = 26,
  parameter int BANK_NUM   = 4,
  parameter bit OUT_REG    = 1'b0,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             CEN,
  input  logic                             GWEN,
  input  logic [BANK_WIDTH*BANK_NUM-1:0]   WEN,
  input  logic [ADDR_WIDTH-1:0]            A,
  input  logic [BANK_WIDTH*BANK_NUM-1:0]   D,
  output logic [BANK_WIDTH*BANK_NUM-1:0]   Q,
  output logic                             BUSY,
  input  logic [ADDR_WIDTH-1:0]            A_t0,
  input  logic                             CEN_t0,
  input  logic                             GWEN_t0,
  input  logic [BANK_WIDTH*BANK_NUM-1:0]   WEN_t0,
  input  logic [BANK_WIDTH*BANK_NUM-1:0]   D_t0,
  output logic [BANK_WIDTH*BANK_NUM-1:0]   Q_t0
);

  localparam int DATA_WIDTH = BANK_WIDTH * BANK_NUM;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic                  a_taint_hold_q;
  logic                  a_taint_q;
  logic                  run;
  logic                  busy;

  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_a_taint;
  logic                  a_taint_now;

  logic [DATA_WIDTH-1:0] q_pre;
  logic [DATA_WIDTH-1:0] q_t_bank;
  logic [DATA_WIDTH-1:0] q_t_pre;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    busy       = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy       = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign run  = (state_q == ST_RUN);
  assign BUSY = busy;

  // --------------------------------------------------- address tracking
  assign a_taint_now = |A_t0;
  assign acc_addr    = CEN ? addr_hold_q : A;
  // The address taint travels with the address actually used.
  assign acc_a_taint = CEN ? a_taint_hold_q : a_taint_now;

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_hold_q    <= '0;
      a_taint_hold_q <= 1'b0;
      a_taint_q      <= 1'b0;
    end else begin
      if (run && !CEN) begin
        addr_hold_q    <= A;
        a_taint_hold_q <= a_taint_now;
      end
      a_taint_q <= run ? acc_a_taint : 1'b0;
    end
  end

  // -------------------------------------------------------------- banks
  for (genvar i = 0; i < BANK_NUM; i++) begin : g_bank
    localparam int MSB = (i + 1) * BANK_WIDTH - 1;

    logic                  bank_we;
    logic                  ctrl_taint;
    logic [BANK_WIDTH-1:0] bank_d_t;

    assign bank_we    = run && !CEN && !GWEN && !WEN[MSB];
    assign ctrl_taint = a_taint_now | CEN_t0 | GWEN_t0 | WEN_t0[MSB];
    assign bank_d_t   = D_t0[i*BANK_WIDTH +: BANK_WIDTH] | {BANK_WIDTH{ctrl_taint}};

    ct_f_spsram_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BANK_WIDTH (BANK_WIDTH)
    ) u_bank (
      .CLK       (CLK),
      .RST       (RST),
      .init_fill (!run),
      .init_addr (init_cnt_q),
      .we        (bank_we),
      .addr      (acc_addr),
      .d         (D[i*BANK_WIDTH +: BANK_WIDTH]),
      .d_t       (bank_d_t),
      .q         (q_pre[i*BANK_WIDTH +: BANK_WIDTH]),
      .q_t       (q_t_bank[i*BANK_WIDTH +: BANK_WIDTH])
    );
  end

  assign q_t_pre = q_t_bank | {DATA_WIDTH{a_taint_q}};

  // ------------------------------------------------------- output stage
  if (OUT_REG) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q_r, q_t_r;
    always_ff @(posedge CLK) begin
      if (RST) begin
        q_r   <= '0;
        q_t_r <= '0;
      end else begin
        q_r   <= q_pre;
        q_t_r <= q_t_pre;
      end
    end
    assign Q    = q_r;
    assign Q_t0 = q_t_r;
  end else begin : g_out_comb
    assign Q    = q_pre;
    assign Q_t0 = q_t_pre;
  end

endmodule

// File: tb/tb_ct_f_spsram_banked_init.sv
module tb_ct_f_spsram_banked_init;

  localparam int AW    = 7;
  localparam int BW    = 26;
  localparam int BN    = 4;
  localparam int DW    = BW * BN;
  localparam int DEPTH = 1 << AW;

  // ---------------------------------------------------- clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cen, gwen;
  logic [DW-1:0] wen, d, wen_t, d_t;
  logic [AW-1:0] a, a_t;
  logic          cen_t, gwen_t;

  logic [DW-1:0] q0, qt0, q1, qt1;
  logic          busy0, busy1;

  // dut: OUT_REG=0, dut_r: OUT_REG=1, same stimulus
  ct_f_spsram_banked_init #(.ADDR_WIDTH(AW), .BANK_WIDTH(BW), .BANK_NUM(BN),
                            .OUT_REG(1'b0), .INIT_EN(1'b1)) dut (
    .CLK(clk), .RST(rst), .CEN(cen), .GWEN(gwen), .WEN(wen), .A(a), .D(d),
    .Q(q0), .BUSY(busy0), .A_t0(a_t), .CEN_t0(cen_t), .GWEN_t0(gwen_t),
    .WEN_t0(wen_t), .D_t0(d_t), .Q_t0(qt0));

  ct_f_spsram_banked_init #(.ADDR_WIDTH(AW), .BANK_WIDTH(BW), .BANK_NUM(BN),
                            .OUT_REG(1'b1), .INIT_EN(1'b1)) dut_r (
    .CLK(clk), .RST(rst), .CEN(cen), .GWEN(gwen), .WEN(wen), .A(a), .D(d),
    .Q(q1), .BUSY(busy1), .A_t0(a_t), .CEN_t0(cen_t), .GWEN_t0(gwen_t),
    .WEN_t0(wen_t), .D_t0(d_t), .Q_t0(qt1));

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------ reference model
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_sh  [DEPTH];
  logic          m_busy;
  int            m_cnt;
  logic [AW-1:0] m_hold;
  logic          m_at_hold;
  logic [DW-1:0] exp_q0, exp_qt0, exp_q1, exp_qt1;

  task automatic set_idle();
    cen = 1'b1; gwen = 1'b1; wen = '1; d = '0; a = '0;
    a_t = '0; cen_t = 1'b0; gwen_t = 1'b0; wen_t = '0; d_t = '0;
  endtask

  // Advance one clock; the model takes the same inputs the DUTs sample.
  task automatic tick();
    logic [AW-1:0] acc;
    logic          at, ctl;
    int            msb;
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b1; m_cnt = 0; m_hold = '0; m_at_hold = 1'b0;
      exp_q0 = '0; exp_qt0 = '0; exp_q1 = '0; exp_qt1 = '0;
    end else if (m_busy) begin
      m_mem[m_cnt] = '0; m_sh[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_busy = 1'b0;
      exp_q1 = exp_q0; exp_qt1 = exp_qt0;
      exp_q0 = '0;     exp_qt0 = '0;
    end else begin
      acc = cen ? m_hold : a;
      at  = cen ? m_at_hold : (|a_t);
      for (int i = 0; i < BN; i++) begin
        msb = (i + 1) * BW - 1;
        if (!cen && !gwen && !wen[msb]) begin
          ctl = (|a_t) | cen_t | gwen_t | wen_t[msb];
          m_mem[acc][i*BW +: BW] = d[i*BW +: BW];
          m_sh[acc][i*BW +: BW]  = d_t[i*BW +: BW] | {BW{ctl}};
        end
      end
      if (!cen) begin m_hold = a; m_at_hold = |a_t; end
      exp_q1 = exp_q0; exp_qt1 = exp_qt0;
      exp_q0 = m_mem[acc];
      exp_qt0 = m_sh[acc] | {DW{at}};
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs out the init phase, returning how many cycles BUSY was seen high.
  task automatic wait_init(output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (!busy0) break;
      n++;
      tick();
    end
  endtask

  // ----------------------------------------------------------- tests
  task automatic test_reset();
    int n;
    set_idle();
    do_reset();
    checks++;
    if (q0 !== '0 || qt0 !== '0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state Q=%h Q_t0=%h BUSY=%b required Q=0 Q_t0=0 BUSY=1", q0, qt0, busy0);
    end
    wait_init(n);
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL init_busy_len got %0d required %0d", n, DEPTH);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL init_busy_outreg BUSY=%b required 0", busy1);
    end
    cen = 1'b0; gwen = 1'b1; a = 7'h7f;
    tick();
    set_idle();
    checks++;
    if (q0 !== '0 || qt0 !== '0) begin
      errors++;
      $display("FAIL read_7f Q=%h Q_t0=%h required 0 0", q0, qt0);
    end
  endtask

  task automatic test_write_mask();
    logic [DW-1:0] req;
    req = '1;
    req[51:26] = '0;
    cen = 1'b0; gwen = 1'b0; a = 7'd5; d = '1; wen = '0; wen[51] = 1'b1;
    tick();
    checks++;
    if (q0 !== req || q0 !== exp_q0) begin
      errors++;
      $display("FAIL mask_write_q Q=%h required %h", q0, req);
    end
    gwen = 1'b1; wen = '1; d = '0;
    tick();
    checks++;
    if (q0 !== req) begin
      errors++;
      $display("FAIL mask_reread_q Q=%h required %h", q0, req);
    end
    checks++;
    if (q1 !== req) begin
      errors++;
      $display("FAIL mask_reread_q_outreg Q=%h required %h", q1, req);
    end
    set_idle();
  endtask

  task automatic test_cen_hold();
    logic [DW-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    cen = 1'b0; gwen = 1'b0; wen = '0; a = 7'd3; d = v;
    tick();
    d = '0; wen = '1; gwen = 1'b1; a = 7'd4;
    tick();
    cen = 1'b0; gwen = 1'b1; a = 7'd3;
    tick();
    checks++;
    if (q0 !== v) begin
      errors++;
      $display("FAIL hold_first_read Q=%h required %h", q0, v);
    end
    checks++;
    if (q1 !== exp_q1 || q1 === v) begin
      errors++;
      $display("FAIL hold_outreg_lag Q=%h required %h", q1, exp_q1);
    end
    cen = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      tick();
      checks++;
      if (q0 !== v || q1 !== v) begin
        errors++;
        $display("FAIL hold_stable cycle %0d Q=%h Qr=%h required %h", k, q0, q1, v);
      end
    end
    set_idle();
  endtask

  task automatic test_reset_mid_init();
    int n;
    cen = 1'b0; gwen = 1'b0; wen = '0; a = 7'd39; d = '1;
    tick();
    set_idle();
    do_reset();
    for (int k = 0; k < 40; k++) tick();
    do_reset();
    wait_init(n);
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL midinit_busy_len got %0d required %0d", n, DEPTH);
    end
    cen = 1'b0; gwen = 1'b1; a = 7'd39;
    tick();
    set_idle();
    checks++;
    if (q0 !== '0 || q0 !== exp_q0) begin
      errors++;
      $display("FAIL midinit_read_39 Q=%h required 0", q0);
    end
  endtask

  task automatic test_taint();
    cen = 1'b0; gwen = 1'b0; wen = '0; a = 7'd9; d = 104'h5a5a; a_t = 7'h01;
    tick();
    set_idle();
    cen = 1'b0; a = 7'd9;
    tick();
    checks++;
    if (qt0 !== '1 || qt0 !== exp_qt0) begin
      errors++;
      $display("FAIL taint_stored Q_t0=%h required all ones", qt0);
    end
    gwen = 1'b0; wen = '0; d = 104'h1234;
    tick();
    gwen = 1'b1; wen = '1;
    tick();
    checks++;
    if (qt0 !== '0 || q0 !== 104'h1234) begin
      errors++;
      $display("FAIL taint_clean Q_t0=%h Q=%h required 0 and 1234", qt0, q0);
    end
    wen_t = '0; wen_t[77] = 1'b1; gwen = 1'b0; wen = '0;
    tick();
    set_idle();
    cen = 1'b0; a = 7'd9;
    tick();
    checks++;
    if (qt0 !== {26'h0, 26'h3ffffff, 52'h0} || qt0 !== exp_qt0) begin
      errors++;
      $display("FAIL taint_wen_bank2 Q_t0=%h required %h", qt0, exp_qt0);
    end
    set_idle();
  endtask

  task automatic test_busy_writes();
    int n;
    do_reset();
    for (int k = 0; k < 30; k++) tick();
    cen = 1'b0; gwen = 1'b0; wen = '0; a = 7'd20; d = '1; a_t = '1;
    for (int k = 0; k < 5; k++) tick();
    set_idle();
    wait_init(n);
    checks++;
    if (n !== DEPTH - 35) begin
      errors++;
      $display("FAIL busy_write_len got %0d required %0d", n, DEPTH - 35);
    end
    cen = 1'b0; a = 7'd20;
    tick();
    set_idle();
    checks++;
    if (q0 !== '0 || qt0 !== '0) begin
      errors++;
      $display("FAIL busy_write_ignored Q=%h Q_t0=%h required 0 0", q0, qt0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cen  = ($urandom_range(0, 3) == 0);
      gwen = $urandom_range(0, 1);
      wen  = {$urandom, $urandom, $urandom, $urandom};
      a    = AW'($urandom_range(0, 15));
      d    = {$urandom, $urandom, $urandom, $urandom};
      a_t  = ($urandom_range(0, 7) == 0) ? AW'(1 << $urandom_range(0, AW - 1)) : '0;
      cen_t  = ($urandom_range(0, 15) == 0);
      gwen_t = ($urandom_range(0, 15) == 0);
      wen_t  = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom, $urandom, $urandom} : '0;
      d_t    = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, $urandom, $urandom} : '0;
      tick();
      checks++;
      if (q0 !== exp_q0 || qt0 !== exp_qt0 || q1 !== exp_q1 || qt1 !== exp_qt1 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL random cycle %0d Q=%h Qt=%h Qr=%h Qrt=%h required %h %h %h %h",
                 k, q0, qt0, q1, qt1, exp_q0, exp_qt0, exp_q1, exp_qt1);
      end
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v [4];
    for (int k = 0; k < 4; k++) begin
      v[k] = {$urandom, $urandom, $urandom, $urandom};
      cen = 1'b0; gwen = 1'b0; wen = '0; a = AW'(100 + k); d = v[k];
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      cen = 1'b0; gwen = 1'b1; wen = '1; a = AW'(100 + k);
      tick();
      checks++;
      if (q0 !== v[k] || q1 !== exp_q1) begin
        errors++;
        $display("FAIL b2b_read %0d Q=%h Qr=%h required %h %h", k, q0, q1, v[k], exp_q1);
      end
    end
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_write_mask();
    test_cen_hold();
    test_taint();
    test_back_to_back();
    test_random();
    test_reset_mid_init();
    test_busy_writes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_f_spsram_banked_init.md
Name: ct_f_spsram_banked_init

Overview:
Parametrised single-port SRAM wrapper, successor to the fixed 128x104 four-bank macro wrappers in the FPGA/sim memory layer.
- Width, depth and bank count are generic.
- Adds a post-reset zero-initialisation sequencer with a BUSY indication.
- Adds an optional output pipeline register.
- Adds a real taint shadow array, replacing the constant-zero Q_t0.
- Drop-in for L1/L2 tag and data arrays once they exceed fixed-geometry variants.

Parameters:
ADDR_WIDTH, 7, address bits; depth = 2**ADDR_WIDTH
BANK_WIDTH, 26, bits per write bank
BANK_NUM, 4, number of banks; DATA_WIDTH = BANK_WIDTH*BANK_NUM (localparam)
OUT_REG, 0, 1 = extra registered stage on Q/Q_t0
INIT_EN, 1, 1 = zero-fill array and shadow after reset

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
CEN  in  1  chip enable, active-low
GWEN  in  1  global write enable, active-low
WEN  in  DATA_WIDTH  per-bit write mask, active-low; bank i uses bit (i+1)*BANK_WIDTH-1
A  in  ADDR_WIDTH  address
D  in  DATA_WIDTH  write data
Q  out  DATA_WIDTH  read data
BUSY  out  1  init in progress, accesses ignored
A_t0, CEN_t0, GWEN_t0, WEN_t0, D_t0  in  same widths as base  taint of inputs
Q_t0  out  DATA_WIDTH  taint of Q

Behaviour:
Clock and reset:
- Single clock CLK; reset RST is synchronous and active-high.
- Reset values: Q=0, Q_t0=0, addr_hold=0, init counter=0. BUSY=INIT_EN.
- FSM state = INIT if INIT_EN, else RUN.
- RST asserted mid-init or mid-access restarts from these values. Any write in the RST cycle is dropped.

FSM:
- INIT:
  - Each cycle writes 0 to all banks and the shadow at the counter address, then increments.
  - Takes 2**ADDR_WIDTH cycles; exits to RUN after writing the last address.
  - BUSY deasserts in the first RUN cycle.
  - External CEN/GWEN/WEN/A/D are ignored; Q is held at 0.
- RUN: normal operation; there is no path back to INIT except RST.
- INIT_EN=0: RUN directly, BUSY=0, contents X in simulation.

Access in RUN:
- Bank i write when !CEN & !GWEN & !WEN[(i+1)*BANK_WIDTH-1].
- Read when !CEN & GWEN.
- Access address = CEN ? addr_hold : A. addr_hold <= A on every !CEN cycle.
- Q latency is 1 cycle from the access edge (OUT_REG=0), or 2 cycles (OUT_REG=1).
- Write-first per bank: written banks return D; masked banks return stored data.
- CEN high: Q re-reads addr_hold and stays stable.
- Back-to-back accesses at full rate; no stalls in RUN.

Taint (RUN only):
- Bank i shadow write uses the same enable as bank i.
- Stored taint = D_t0 slice OR replicated (|A_t0 | CEN_t0 | GWEN_t0 | WEN_t0[(i+1)*BANK_WIDTH-1]).
- Q_t0 = shadow[access address] OR replicated (|A_t0 captured at the access edge).
- Q_t0 follows the same latency and write-first rule as Q.
- INIT clears the shadow to 0.

Decomposition:
- No shared package; geometry is localparams derived from the parameters (DATA_WIDTH, DEPTH).
- FSM encoding is a local 1-bit localparam pair: INIT, RUN.
- One sub-module: ct_f_spsram_bank, holding BANK_WIDTH x DEPTH storage, taint shadow, write-first read register and a zero-fill write port mux.
- The sub-module is instantiated BANK_NUM times by generate.
- The top holds the FSM, init counter, addr_hold, taint OR-logic and the OUT_REG stage.

Test Plan:
1. Reset, INIT_EN=1, ADDR_WIDTH=7 -> BUSY=1 for exactly 128 cycles after RST falls; then read addr 0x7F -> Q=0, Q_t0=0.
2. Write addr 5, D=all-ones, WEN bank-1 MSB=1 (others 0) -> same-cycle-next Q = ones except bits 51:26 = 0; re-read addr 5 gives the same.
3. Read addr 3 then hold CEN=1 for 10 cycles while A toggles -> Q stays at mem[3]. OUT_REG=1 shows the data one cycle later than OUT_REG=0.
4. RST pulsed at init count 40 -> counter restarts; BUSY stays high for 128 cycles after the second RST; addr 39 reads 0.
5. Write addr 9 with D_t0=0, A_t0=1, then read addr 9 with all taints 0 -> Q_t0 = all-ones. Rewrite with clean taint -> Q_t0=0.
6. CEN=0 writes attempted while BUSY=1 -> no effect; post-init read of that address returns 0.
